// File: rtl/n64adv_igr_pkg.sv
// Shared definitions for the in-game-reset / OSD navigation decoder.
// Holds controller word bit positions, combo FSM encodings, nav event bit
// positions, default combo patterns and the axis byte bit-reversal helper.
package n64adv_igr_pkg;

  // Button positions in the low 16 bits of the controller word
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_DU = 4;
  localparam int BTN_DD = 5;
  localparam int BTN_DL = 6;
  localparam int BTN_DR = 7;

  // nav_evt bit positions; lowest index has highest priority
  localparam int NAV_UP = 0;
  localparam int NAV_DN = 1;
  localparam int NAV_LT = 2;
  localparam int NAV_RT = 3;
  localparam int NAV_A  = 4;
  localparam int NAV_B  = 5;

  localparam logic [1:0] CMB_IDLE    = 2'd0;
  localparam logic [1:0] CMB_ARM     = 2'd1;
  localparam logic [1:0] CMB_WAITREL = 2'd2;

  // L+R+Z+Start+A+B for reset, project menu pattern for the OSD toggle
  localparam logic [15:0] COMBO_RST_DEF  = 16'h0C0F;
  localparam logic [15:0] COMBO_MENU_DEF = 16'h0330;

  typedef enum logic {SEL_RST = 1'b0, SEL_MENU = 1'b1} combo_sel_e;

  // Axis bytes arrive MSB-first at the lowest index
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/n64adv_nav_repeat.sv
// OSD navigation arbitration and auto-repeat.
//   clk, rst  : clock, synchronous active-high reset
//   req[5:0]  : {B,A,Right,Left,Down,Up} requests for the current poll
//   poll      : one-cycle strobe, req is valid
//   en        : navigation allowed; low clears the repeat state
//   nav_evt   : registered one-cycle event pulses, at most one bit set
module n64adv_nav_repeat
  import n64adv_igr_pkg::*;
#(
  parameter logic [4:0] REP_DELAY = 5'd20,
  parameter logic [2:0] REP_RATE  = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  input  logic       poll,
  input  logic       en,
  output logic [5:0] nav_evt
);

  localparam logic [5:0] REP_FIRST = {1'b0, REP_DELAY};
  // Counter runs REP_FIRST+1 .. REP_TOP once repeating, so it never falls
  // back below the initial delay and never overflows.
  localparam logic [5:0] REP_TOP   = REP_FIRST + {3'b000, REP_RATE};

  logic [5:0] pick;
  logic [5:0] prev_q, prev_d;
  logic [5:0] rep_q, rep_d;
  logic [5:0] evt_q, evt_d;

  // Isolate the lowest set request bit: Up wins over everything else
  assign pick = req & (~req + 6'd1);

  always_comb begin
    prev_d = prev_q;
    rep_d  = rep_q;
    evt_d  = '0;
    if (!en) begin
      prev_d = '0;
      rep_d  = '0;
    end else if (poll) begin
      if (pick == '0) begin
        prev_d = '0;
        rep_d  = '0;
      end else if (pick != prev_q) begin
        evt_d  = pick;
        prev_d = pick;
        rep_d  = '0;
      end else begin
        rep_d = (rep_q == REP_TOP) ? REP_FIRST + 6'd1 : rep_q + 6'd1;
        if (!(pick[NAV_A] || pick[NAV_B]) &&
            (rep_d == REP_FIRST || rep_d == REP_TOP))
          evt_d = pick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rep_q  <= '0;
      evt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      rep_q  <= rep_d;
      evt_q  <= evt_d;
    end
  end

  assign nav_evt = evt_q;

endmodule

// File: rtl/n64adv_igr_decoder.sv
// Controller word decoder: hold-to-fire reset/menu combos, OSD navigation
// events and controller presence detection, in the CLK_4M domain.
//   clk, rst      : clock, synchronous active-high reset
//   ctrl_data     : controller word (buttons [15:0], X [23:16], Y [31:24])
//   ctrl_valid    : one-cycle strobe per poll
//   use_igr       : enables combo detection
//   osd_active    : enables navigation events
//   ctrl_present  : a word was seen within TIMEOUT cycles
//   rst_req       : one-cycle pulse, reset combo fired
//   menu_toggle   : one-cycle pulse, menu combo fired
//   nav_evt       : one-cycle pulses {B,A,Right,Left,Down,Up}
//   btn_state     : low 16 bits of the last word
// Stage 1 latches the word; stage 2 decides, so results appear two edges
// after the strobe.
module n64adv_igr_decoder
  import n64adv_igr_pkg::*;
#(
  parameter logic [15:0] COMBO_RST  = COMBO_RST_DEF,
  parameter logic [15:0] COMBO_MENU = COMBO_MENU_DEF,
  parameter logic [5:0]  HOLD_POLLS = 6'd30,
  parameter logic [4:0]  REP_DELAY  = 5'd20,
  parameter logic [2:0]  REP_RATE   = 3'd4,
  parameter logic [6:0]  STICK_THR  = 7'd40,
  parameter logic [19:0] TIMEOUT    = 20'd400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_data,
  input  logic        ctrl_valid,
  input  logic        use_igr,
  input  logic        osd_active,
  output logic        ctrl_present,
  output logic        rst_req,
  output logic        menu_toggle,
  output logic [5:0]  nav_evt,
  output logic [15:0] btn_state
);

  logic [15:0]       btn_q, btn_d;
  logic signed [7:0] x_q, x_d, y_q, y_d;
  logic              poll_q, poll_d;
  logic [19:0]       to_cnt_q, to_cnt_d;
  logic              present_q, present_d;
  logic              lost;
  logic [1:0]        cmb_q, cmb_d;
  combo_sel_e        sel_q, sel_d;
  logic [5:0]        hold_q, hold_d, hold_inc;
  logic              rst_req_q, rst_req_d;
  logic              menu_q, menu_d;
  logic [15:0]       btn_state_q, btn_state_d;
  logic              match_rst, match_menu, cur_match;
  logic signed [7:0] thr;
  logic [5:0]        req;
  logic              nav_en;

  // Input stage and presence counter; a strobe always clears the counter,
  // even in the cycle it would have saturated.
  always_comb begin
    poll_d    = ctrl_valid;
    btn_d     = ctrl_valid ? ctrl_data[15:0] : btn_q;
    x_d       = ctrl_valid ? $signed(bitrev8(ctrl_data[23:16])) : x_q;
    y_d       = ctrl_valid ? $signed(bitrev8(ctrl_data[31:24])) : y_q;
    to_cnt_d  = ctrl_valid ? '0 :
                (to_cnt_q >= TIMEOUT) ? TIMEOUT : to_cnt_q + 20'd1;
    lost      = (to_cnt_d == TIMEOUT);
    present_d = (to_cnt_d < TIMEOUT);
  end

  assign match_rst  = (btn_q == COMBO_RST);
  assign match_menu = (btn_q == COMBO_MENU);
  assign cur_match  = (sel_q == SEL_RST) ? match_rst : match_menu;
  assign hold_inc   = hold_q + 6'd1;

  // Combo FSM, stepped once per poll
  always_comb begin
    cmb_d       = cmb_q;
    sel_d       = sel_q;
    hold_d      = hold_q;
    rst_req_d   = 1'b0;
    menu_d      = 1'b0;
    btn_state_d = lost ? '0 : (poll_q ? btn_q : btn_state_q);
    if (!use_igr || lost) begin
      cmb_d  = CMB_IDLE;
      hold_d = '0;
    end else if (poll_q) begin
      case (cmb_q)
        CMB_IDLE: begin
          if (match_rst || match_menu) begin
            cmb_d  = CMB_ARM;
            sel_d  = match_rst ? SEL_RST : SEL_MENU;
            hold_d = 6'd1;
          end
        end
        CMB_ARM: begin
          if (cur_match) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_POLLS) begin
              rst_req_d = (sel_q == SEL_RST);
              menu_d    = (sel_q == SEL_MENU);
              cmb_d     = CMB_WAITREL;
              hold_d    = '0;
            end
          end else if (match_rst || match_menu) begin
            // switched straight to the other combo: restart its hold
            sel_d  = match_rst ? SEL_RST : SEL_MENU;
            hold_d = 6'd1;
          end else begin
            cmb_d  = CMB_IDLE;
            hold_d = '0;
          end
        end
        CMB_WAITREL: begin
          if (btn_q == '0) cmb_d = CMB_IDLE;
        end
        default: begin
          cmb_d  = CMB_IDLE;
          hold_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      poll_q      <= 1'b0;
      to_cnt_q    <= '0;
      present_q   <= 1'b0;
      cmb_q       <= CMB_IDLE;
      sel_q       <= SEL_RST;
      hold_q      <= '0;
      rst_req_q   <= 1'b0;
      menu_q      <= 1'b0;
      btn_state_q <= '0;
    end else begin
      btn_q       <= btn_d;
      x_q         <= x_d;
      y_q         <= y_d;
      poll_q      <= poll_d;
      to_cnt_q    <= to_cnt_d;
      present_q   <= present_d;
      cmb_q       <= cmb_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
      rst_req_q   <= rst_req_d;
      menu_q      <= menu_d;
      btn_state_q <= btn_state_d;
    end
  end

  // Stick thresholds are strict: exactly +/-STICK_THR does not navigate
  assign thr         = $signed({1'b0, STICK_THR});
  assign req[NAV_UP] = btn_q[BTN_DU] | (y_q > thr);
  assign req[NAV_DN] = btn_q[BTN_DD] | (y_q < -thr);
  assign req[NAV_LT] = btn_q[BTN_DL] | (x_q < -thr);
  assign req[NAV_RT] = btn_q[BTN_DR] | (x_q > thr);
  assign req[NAV_A]  = btn_q[BTN_A];
  assign req[NAV_B]  = btn_q[BTN_B];

  assign nav_en = osd_active && (cmb_q == CMB_IDLE) && !lost;

  n64adv_nav_repeat #(
    .REP_DELAY(REP_DELAY),
    .REP_RATE (REP_RATE)
  ) u_nav (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .poll   (poll_q),
    .en     (nav_en),
    .nav_evt(nav_evt)
  );

  assign ctrl_present = present_q;
  assign rst_req      = rst_req_q;
  assign menu_toggle  = menu_q;
  assign btn_state    = btn_state_q;

endmodule

// File: tb/tb_n64adv_igr_decoder.sv
// Scoreboard bench for n64adv_igr_decoder: each poll pushes its expected
// {rst_req, menu_toggle, nav_evt, btn_state}; a monitor pops and compares
// two edges after the strobe and requires silent pulse outputs otherwise.
module tb_n64adv_igr_decoder;

  localparam logic [19:0] TO       = 20'd64;
  localparam logic [15:0] C_RST    = 16'h0C0F;
  localparam logic [15:0] C_MENU   = 16'h0330;
  localparam logic [5:0]  EV_U     = 6'b000001;
  localparam logic [5:0]  EV_D     = 6'b000010;
  localparam logic [5:0]  EV_R     = 6'b001000;
  localparam logic [5:0]  EV_A     = 6'b010000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic        use_igr;
  logic        osd_active;
  logic        ctrl_present;
  logic        rst_req;
  logic        menu_toggle;
  logic [5:0]  nav_evt;
  logic [15:0] btn_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [23:0] sb[$];
  logic [1:0]  vpipe = 2'b00;

  always #5 clk = ~clk;

  n64adv_igr_decoder #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_data   (ctrl_data),
    .ctrl_valid  (ctrl_valid),
    .use_igr     (use_igr),
    .osd_active  (osd_active),
    .ctrl_present(ctrl_present),
    .rst_req     (rst_req),
    .menu_toggle (menu_toggle),
    .nav_evt     (nav_evt),
    .btn_state   (btn_state)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One poll: strobe a word, queue the expected result, leave a 4-cycle slot
  task automatic poll(input logic [31:0] w, input logic er, input logic em,
                      input logic [5:0] en);
    @(negedge clk);
    ctrl_data  = w;
    ctrl_valid = 1'b1;
    sb.push_back({er, em, en, w[15:0]});
    @(negedge clk);
    ctrl_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) vpipe <= {vpipe[0], ctrl_valid & ~rst};

  initial begin : monitor
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (vpipe[1]) begin
        chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rst_req", 32'(rst_req), 32'(e[23]));
          chk("menu_toggle", 32'(menu_toggle), 32'(e[22]));
          chk("nav_evt", 32'(nav_evt), 32'(e[21:16]));
          chk("btn_state", 32'(btn_state), 32'(e[15:0]));
          chk("present", 32'(ctrl_present), 32'd1);
        end
      end else begin
        chk("quiet_pulses", {24'd0, rst_req, menu_toggle, nav_evt}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; ctrl_valid = 1'b0; ctrl_data = '0; use_igr = 1'b0; osd_active = 1'b0;

    // reset with words streaming: everything stays at zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_outs", {9'd0, ctrl_present, rst_req, menu_toggle, nav_evt, btn_state}, 32'd0);
      ctrl_data  = 32'h0000_0C0F + 32'(i);
      ctrl_valid = 1'b1;
    end
    @(negedge clk);
    ctrl_valid = 1'b0;
    rst = 1'b0;

    // first word: not visible one edge after the strobe, visible after two
    @(negedge clk);
    ctrl_data = 32'h0000_1234; ctrl_valid = 1'b1;
    sb.push_back({1'b0, 1'b0, 6'd0, 16'h1234});
    @(posedge clk); #2;
    chk("btn_state_early", 32'(btn_state), 32'd0);
    @(negedge clk); ctrl_valid = 1'b0;
    repeat (2) @(negedge clk);

    // reset combo: fires once on poll 30, silent while held, re-fires after release
    use_igr = 1'b1;
    for (int i = 1; i <= 40; i++) poll({16'd0, C_RST}, i == 30, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);
    for (int i = 1; i <= 30; i++) poll({16'd0, C_RST}, i == 30, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // menu combo broken on poll 30 by an extra bit: no toggle, back to idle
    for (int i = 1; i <= 29; i++) poll({16'd0, C_MENU}, 1'b0, 1'b0, 6'd0);
    poll(32'h0000_0331, 1'b0, 1'b0, 6'd0);
    osd_active = 1'b1;
    poll(32'h0000_0001, 1'b0, 1'b0, EV_A);  // nav only works in idle
    poll(32'd0, 1'b0, 1'b0, 6'd0);
    osd_active = 1'b0;

    // menu combo held to completion
    for (int i = 1; i <= 30; i++) poll({16'd0, C_MENU}, 1'b0, i == 30, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // use_igr dropping mid-arm restarts the hold count
    for (int i = 1; i <= 10; i++) poll({16'd0, C_RST}, 1'b0, 1'b0, 6'd0);
    use_igr = 1'b0;
    poll({16'd0, C_RST}, 1'b0, 1'b0, 6'd0);
    use_igr = 1'b1;
    for (int i = 1; i <= 30; i++) poll({16'd0, C_RST}, i == 30, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // combo press seen by nav on the arming poll only
    osd_active = 1'b1;
    poll({16'd0, C_MENU}, 1'b0, 1'b0, EV_U);
    poll({16'd0, C_MENU}, 1'b0, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);
    use_igr = 1'b0;

    // D-pad down held: initial, delayed, then periodic repeats
    for (int i = 1; i <= 40; i++)
      poll(32'h0000_0020, 1'b0, 1'b0, (i inside {1, 21, 25, 29, 33, 37}) ? EV_D : 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // A never repeats
    for (int i = 1; i <= 25; i++) poll(32'h0000_0001, 1'b0, 1'b0, (i == 1) ? EV_A : 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // priority Up over Right and A, then a direction change fires at once
    poll(32'h0000_0091, 1'b0, 1'b0, EV_U);
    poll(32'h0000_0080, 1'b0, 1'b0, EV_R);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // stick: X +80 -> Right, X +40 -> nothing, Y -80 -> Down
    poll(32'h000A_0000, 1'b0, 1'b0, EV_R);
    poll(32'd0, 1'b0, 1'b0, 6'd0);
    poll(32'h0014_0000, 1'b0, 1'b0, 6'd0);
    poll(32'h0D00_0000, 1'b0, 1'b0, EV_D);
    poll(32'd0, 1'b0, 1'b0, 6'd0);
    osd_active = 1'b0;

    // controller loss aborts an armed combo and clears btn_state
    use_igr = 1'b1;
    for (int i = 1; i <= 10; i++) poll({16'd0, C_RST}, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    ctrl_data = {16'd0, C_RST}; ctrl_valid = 1'b1;
    sb.push_back({1'b0, 1'b0, 6'd0, C_RST});
    @(posedge clk);
    #1 ctrl_valid = 1'b0;
    for (int n = 1; n <= int'(TO); n++) begin
      @(posedge clk); #2;
      if (n == int'(TO) - 1) chk("present_before_to", 32'(ctrl_present), 32'd1);
      if (n == int'(TO)) begin
        chk("present_at_to", 32'(ctrl_present), 32'd0);
        chk("btn_state_at_to", 32'(btn_state), 32'd0);
      end
    end
    for (int i = 1; i <= 30; i++) poll({16'd0, C_RST}, i == 30, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    // reset in the middle of an armed hold aborts it
    for (int i = 1; i <= 10; i++) poll({16'd0, C_RST}, 1'b0, 1'b0, 6'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) poll({16'd0, C_RST}, i == 30, 1'b0, 6'd0);
    poll(32'd0, 1'b0, 1'b0, 6'd0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
